spi_adc_responder: RTL and testbench
====================================

Name: spi_adc_responder

Overview:
- SPI slave that emulates the 12-bit serial ADC read by the SPI master state machine; it is the other end of that link.
- Serves a 16-bit frame on MISO (LEAD_ZEROS zeros, then a DATA_W-bit sample, MSB first) while CS is low.
- Captures the bits the master drives on MOSI during the same frame.
- Used for loop-back self-test on-chip and as an ADC stand-in in simulation. SCK/CS/MOSI are oversampled in the clk domain.

Parameters:
- DATA_W, 12, sample width in bits.
- LEAD_ZEROS, 4, zero bits sent ahead of the sample; FRAME_BITS = LEAD_ZEROS + DATA_W = 16.
- SYNC_STAGES, 2, flip-flop stages on SCK/CS/MOSI inputs (minimum 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_sample_data  input  DATA_W  sample value to serve.
- i_sample_valid  input  1  loads i_sample_data into the hold register.
- SCK  input  1  serial clock from master (idle high or low).
- CS  input  1  active-low chip select from master.
- MOSI  input  1  master data, sampled on SCK rising edge.
- MISO  output  1  slave data; changes after SCK falling edge.
- o_miso_oe  output  1  high while a frame is active (tristate enable).
- o_busy  output  1  high from CS fall detection until CS rise detection.
- o_sample_taken  output  1  1-cycle pulse when the hold register is copied to the shifter.
- o_frame_done  output  1  1-cycle pulse after the FRAME_BITS-th SCK falling edge.
- o_frame_abort  output  1  1-cycle pulse when CS rises before frame completion.
- o_rx_data  output  FRAME_BITS  MOSI bits of the last completed frame, first bit in MSB.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - MISO=0, o_miso_oe=0, o_busy=0, all pulses 0, o_rx_data=0.
  - Hold register, shifter, bit counter and synchronizers cleared; state = IDLE.
- Input conditioning:
  - SCK, CS and MOSI pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last sync stage with one further flop.
  - Edge detect to action latency is SYNC_STAGES+1 clk cycles.
  - Valid operation requires f_SCK ≤ f_clk/8, with each SCK phase ≥ 4 clk cycles.
- Hold register: loads i_sample_data on any cycle with i_sample_valid=1, including mid-frame. It never disturbs the frame in flight.
- State IDLE:
  - MISO=0, o_miso_oe=0.
  - On CS falling edge: shifter <= {LEAD_ZEROS'b0, hold}, using the hold value before any same-cycle i_sample_valid load.
  - Same transition: bit_cnt <= 0, rx shift <= 0, o_sample_taken pulse, go to ACTIVE.
  - MISO presents shifter MSB in the next cycle.
- State ACTIVE:
  - o_busy=1, o_miso_oe=1, MISO = shifter MSB.
  - SCK rising edge: rx shift <= {rx[FRAME_BITS-2:0], MOSI_sync}.
  - SCK falling edge: shifter shifts left with 0 fill; bit_cnt++.
  - When bit_cnt reaches FRAME_BITS (16th falling edge): o_rx_data <= rx shift, o_frame_done pulse, go to DONE.
  - CS rising edge: o_frame_abort pulse, o_rx_data unchanged, go to IDLE. This takes priority over an SCK edge detected in the same cycle.
- State DONE:
  - MISO=0, o_miso_oe=1, o_busy=1.
  - Extra SCK edges are ignored; bit_cnt saturates.
  - CS rising edge: go to IDLE with no pulse.
- SCK edges while CS is high are ignored in IDLE.
- A CS rise and fall seen in consecutive cycles is handled as two distinct events: abort or completion first, then a new frame.
- Bit counter is 5 bits wide, holds 0..FRAME_BITS and never wraps.
- Reset asserted mid-frame: all outputs return immediately to reset values. After release, the block stays IDLE until a fresh CS falling edge; a CS already low at release does not start a frame.
- Latency: MISO bit n+1 is valid SYNC_STAGES+2 clk cycles after the n-th SCK falling pin edge. It is stable well before the next rising edge at the permitted SCK rate.

Test Plan:
- Reset: hold rst_n=0 with CS low and SCK toggling -> MISO=0, o_miso_oe=0, o_busy=0, o_rx_data=0, no pulses.
- Normal read: i_sample_valid with 0xA5C, then a 16-clock frame with SCK=clk/8 -> master samples 0000_1010_0101_1100, one o_sample_taken, one o_frame_done, o_busy falls 3 cycles after CS rise.
- MOSI capture: master drives 0x1234 during a frame -> o_rx_data=16'h1234 when o_frame_done pulses.
- Early abort: CS rises after 5 SCK periods -> o_frame_abort pulses once, no o_frame_done, o_rx_data keeps its previous value, and the next frame starts from bit 0.
- Same-cycle collision: i_sample_valid with 0x0FF in the same cycle CS fall is detected, hold previously 0x123 -> frame carries 0x123 and the next frame carries 0x0FF.
- Back-to-back frames plus mid-frame reset: two frames with CS high for only 4 clk cycles -> two o_frame_done pulses. Then rst_n pulsed at bit 7 -> outputs reset, and a new CS fall gives a complete, correct frame.

Source files
------------

// File: rtl/spi_adc_responder.sv
// spi_adc_responder: SPI slave emulating a 12-bit serial ADC; serves a 16-bit frame
// (leading zeros + sample, MSB first) on MISO and captures the master's MOSI bits.
module spi_adc_responder #(
    parameter int DATA_W      = 12,
    parameter int LEAD_ZEROS  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_W-1:0]            i_sample_data,
    input  logic                         i_sample_valid,
    input  logic                         SCK,
    input  logic                         CS,
    input  logic                         MOSI,
    output logic                         MISO,
    output logic                         o_miso_oe,
    output logic                         o_busy,
    output logic                         o_sample_taken,
    output logic                         o_frame_done,
    output logic                         o_frame_abort,
    output logic [LEAD_ZEROS+DATA_W-1:0] o_rx_data
);
    localparam int FRAME_BITS = LEAD_ZEROS + DATA_W;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                    sck_prev_q, cs_prev_q;
    logic [DATA_W-1:0]       hold_q;
    logic [FRAME_BITS-1:0]   shift_q, shift_d, rx_q, rx_d, rx_data_q, rx_data_d;
    logic [4:0]              cnt_q, cnt_d;
    logic                    taken_q, taken_d, done_q, done_d, abort_q, abort_d;
    logic                    sck_s, cs_s, mosi_s, sck_rise, sck_fall, cs_rise, cs_fall;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
            hold_q      <= '0;
            state_q     <= IDLE;
            shift_q     <= '0;
            rx_q        <= '0;
            rx_data_q   <= '0;
            cnt_q       <= '0;
            taken_q     <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
            hold_q      <= i_sample_valid ? i_sample_data : hold_q;
            state_q     <= state_d;
            shift_q     <= shift_d;
            rx_q        <= rx_d;
            rx_data_q   <= rx_data_d;
            cnt_q       <= cnt_d;
            taken_q     <= taken_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
        end
    end

    // The shifter loads the hold value registered before this cycle, so a
    // same-cycle sample load only affects the next frame.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        cnt_d     = cnt_q;
        taken_d   = 1'b0;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        case (state_q)
            IDLE: if (cs_fall) begin
                shift_d = {{LEAD_ZEROS{1'b0}}, hold_q};
                cnt_d   = '0;
                rx_d    = '0;
                taken_d = 1'b1;
                state_d = ACTIVE;
            end
            ACTIVE: if (cs_rise) begin
                abort_d = 1'b1;
                state_d = IDLE;
            end else begin
                if (sck_rise) rx_d = {rx_q[FRAME_BITS-2:0], mosi_s};
                if (sck_fall) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'(FRAME_BITS - 1)) begin
                        rx_data_d = rx_q;
                        done_d    = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE: if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign MISO           = (state_q == ACTIVE) & shift_q[FRAME_BITS-1];
    assign o_miso_oe      = state_q != IDLE;
    assign o_busy         = state_q != IDLE;
    assign o_sample_taken = taken_q;
    assign o_frame_done   = done_q;
    assign o_frame_abort  = abort_q;
    assign o_rx_data      = rx_data_q;
endmodule

// File: tb/tb_spi_adc_responder.sv
// tb_spi_adc_responder: directed, table-driven bench for spi_adc_responder.
module tb_spi_adc_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] i_sample_data = '0;
    logic        i_sample_valid = 1'b0;
    logic        SCK = 1'b0;
    logic        CS = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO, o_miso_oe, o_busy, o_sample_taken, o_frame_done, o_frame_abort;
    logic [15:0] o_rx_data;

    int checks = 0;
    int failures = 0;
    int n_taken = 0, n_done = 0, n_abort = 0;

    spi_adc_responder dut (
        .clk(clk), .rst_n(rst_n), .i_sample_data(i_sample_data), .i_sample_valid(i_sample_valid),
        .SCK(SCK), .CS(CS), .MOSI(MOSI), .MISO(MISO), .o_miso_oe(o_miso_oe), .o_busy(o_busy),
        .o_sample_taken(o_sample_taken), .o_frame_done(o_frame_done),
        .o_frame_abort(o_frame_abort), .o_rx_data(o_rx_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n) begin
        n_taken <= n_taken + int'(o_sample_taken);
        n_done  <= n_done + int'(o_frame_done);
        n_abort <= n_abort + int'(o_frame_abort);
    end

    typedef struct {
        logic [11:0] smp;
        logic [15:0] mo;
        logic [15:0] exp_mi;
        logic [15:0] exp_rx;
    } vec_t;
    vec_t tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Master with SCK idle low: MISO sampled just before each rising edge, each phase 4 clk.
    task automatic run_bits(input logic [15:0] mo, input int n, output logic [15:0] mi);
        mi = '0;
        for (int i = 0; i < n; i++) begin
            MOSI = mo[15-i];
            repeat (4) @(negedge clk);
            mi[15-i] = MISO;
            SCK = 1'b1;
            repeat (4) @(negedge clk);
            SCK = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic end_frame(input string tag, input int gap);
        CS = 1'b1;
        repeat (2) @(negedge clk);
        check({tag, " busy_hold"}, 32'(o_busy), 32'd1);
        @(negedge clk);
        check({tag, " busy_fall"}, 32'(o_busy), 32'd0);
        repeat (gap - 3) @(negedge clk);
    endtask

    task automatic do_frame(input string tag, input logic load, input logic [11:0] smp,
                            input logic [15:0] mo, input logic [15:0] exp_mi,
                            input logic [15:0] exp_rx, input int gap, input logic collide);
        int t0, d0, a0;
        logic [15:0] mi;
        if (load) begin
            i_sample_data = smp;
            i_sample_valid = 1'b1;
            @(negedge clk);
            i_sample_valid = 1'b0;
            @(negedge clk);
        end
        t0 = n_taken; d0 = n_done; a0 = n_abort;
        CS = 1'b0;
        if (collide) begin
            repeat (2) @(negedge clk);
            i_sample_data = 12'h0FF;
            i_sample_valid = 1'b1;
            @(negedge clk);
            i_sample_valid = 1'b0;
        end
        run_bits(mo, 16, mi);
        check({tag, " miso"}, 32'(mi), 32'(exp_mi));
        check({tag, " rx_data"}, 32'(o_rx_data), 32'(exp_rx));
        check({tag, " taken"}, 32'(n_taken - t0), 32'd1);
        check({tag, " done"}, 32'(n_done - d0), 32'd1);
        check({tag, " abort"}, 32'(n_abort - a0), 32'd0);
        end_frame(tag, gap);
    endtask

    initial begin
        logic [15:0] mi;
        logic        pulses;
        int          t0, d0, a0;
        tbl[0] = '{12'hA5C, 16'h1234, 16'h0A5C, 16'h1234};
        tbl[1] = '{12'hFFF, 16'h0000, 16'h0FFF, 16'h0000};
        tbl[2] = '{12'h000, 16'hFFFF, 16'h0000, 16'hFFFF};
        tbl[3] = '{12'h801, 16'h8001, 16'h0801, 16'h8001};

        // Reset held with CS low and SCK toggling
        CS = 1'b0;
        pulses = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            SCK = ~SCK;
            pulses = pulses | o_sample_taken | o_frame_done | o_frame_abort;
        end
        SCK = 1'b0;
        check("rst miso", 32'(MISO), 32'd0);
        check("rst oe", 32'(o_miso_oe), 32'd0);
        check("rst busy", 32'(o_busy), 32'd0);
        check("rst rx_data", 32'(o_rx_data), 32'd0);
        check("rst pulses", 32'(pulses), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rel cs_low busy", 32'(o_busy), 32'd0);
        check("rel cs_low taken", 32'(n_taken), 32'd0);
        CS = 1'b1;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 4; i++)
            do_frame($sformatf("vec%0d", i), 1'b1, tbl[i].smp, tbl[i].mo, tbl[i].exp_mi,
                     tbl[i].exp_rx, 8, 1'b0);

        // Early abort after 5 SCK periods; hold is still 0x801
        t0 = n_taken; d0 = n_done; a0 = n_abort;
        CS = 1'b0;
        run_bits(16'hFFFF, 5, mi);
        check("abort partial miso", 32'(mi), 32'h0800);
        end_frame("abort", 8);
        check("abort pulse", 32'(n_abort - a0), 32'd1);
        check("abort no done", 32'(n_done - d0), 32'd0);
        check("abort taken", 32'(n_taken - t0), 32'd1);
        check("abort rx kept", 32'(o_rx_data), 32'h8001);
        do_frame("post_abort", 1'b0, 12'h000, 16'h5555, 16'h0801, 16'h5555, 8, 1'b0);

        // Sample load in the same cycle the CS fall is acted on
        do_frame("collide", 1'b1, 12'h123, 16'h0F0F, 16'h0123, 16'h0F0F, 8, 1'b1);
        do_frame("after_collide", 1'b0, 12'h000, 16'hA0A0, 16'h00FF, 16'hA0A0, 8, 1'b0);

        // Back-to-back frames with CS high for 4 clk
        do_frame("b2b0", 1'b1, 12'h7E5, 16'hC3C3, 16'h07E5, 16'hC3C3, 4, 1'b0);
        do_frame("b2b1", 1'b0, 12'h000, 16'h3C3C, 16'h07E5, 16'h3C3C, 8, 1'b0);

        // Reset mid-frame at bit 7
        CS = 1'b0;
        run_bits(16'hFFFF, 7, mi);
        rst_n = 1'b0;
        #1;
        check("midrst miso", 32'(MISO), 32'd0);
        check("midrst oe", 32'(o_miso_oe), 32'd0);
        check("midrst busy", 32'(o_busy), 32'd0);
        check("midrst rx_data", 32'(o_rx_data), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst cs_low idle", 32'(o_busy), 32'd0);
        CS = 1'b1;
        repeat (8) @(negedge clk);
        do_frame("post_rst_hold0", 1'b0, 12'h000, 16'hBEEF, 16'h0000, 16'hBEEF, 8, 1'b0);
        do_frame("post_rst", 1'b1, 12'h3C7, 16'h9696, 16'h03C7, 16'h9696, 8, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
